mem_arbiter_n: RTL and testbench

- Parametrised N-port arbiter that shares one fixed-latency backing memory among several requesters (I-fetch, D-mem, future DMA/second core).
- Successor of the 2-port IF/MEM memory interface. Adds configurable port count, latency and data widths, a selectable fixed or round-robin priority, per-port completion pulses, and zero-bubble back-to-back grants.
- Sits between pipeline stages and main memory; the cpu top drives the global stall from its stall outputs.

---
 rtl/mem_arbiter_n.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_n.sv
// N-port arbiter sharing one fixed-latency backing memory.
// Fixed (highest index) or round-robin priority, zero-bubble back-to-back grants.
module mem_arbiter_n #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_LATENCY = 4,
    parameter int RR_MODE     = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        stall,
    output logic [NUM_PORTS-1:0]        done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]        CNT_LAST = CW'(MEM_LATENCY - 1);
    localparam logic [PW-1:0]        PTR_INIT = PW'(NUM_PORTS - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_r, state_s;
    logic [CW-1:0]        cnt_r, cnt_s;
    logic [PW-1:0]        owner_r, rr_ptr_r, win_s;
    logic                 win_vld_s, done_cyc_s, rd_done_s;
    logic [NUM_PORTS-1:0] cand_s;
    logic                 mem_en_r, mem_wr_r;
    logic [ADDR_W-1:0]    mem_addr_r;
    logic [DATA_W-1:0]    mem_wdata_r, rdata_r;

    // Done-cycle detection and arbitration candidates (finishing owner excluded)
    always_comb begin
        done_cyc_s = (state_r == BUSY) && (cnt_r == CNT_LAST);
        rd_done_s  = done_cyc_s && !mem_wr_r;
        cand_s     = {NUM_PORTS{1'b0}};
        if (state_r == IDLE) begin
            cand_s = req;
        end else if (done_cyc_s) begin
            cand_s = req & ~(ONE_HOT0 << owner_r);
        end else begin
            cand_s = {NUM_PORTS{1'b0}};
        end
    end

    // Winner selection: round-robin from pointer+1, or highest pending index
    always_comb begin
        win_s     = {PW{1'b0}};
        win_vld_s = 1'b0;
        if (RR_MODE != 0) begin
            for (int k = 1; k <= NUM_PORTS; k++) begin
                logic take;
                take      = !win_vld_s && cand_s[PW'((int'(rr_ptr_r) + k) % NUM_PORTS)];
                win_s     = take ? PW'((int'(rr_ptr_r) + k) % NUM_PORTS) : win_s;
                win_vld_s = win_vld_s | take;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                win_s     = cand_s[i] ? PW'(i) : win_s;
                win_vld_s = win_vld_s | cand_s[i];
            end
        end
    end

    // Next-state and latency counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                cnt_s   = {CW{1'b0}};
                state_s = win_vld_s ? BUSY : IDLE;
            end
            BUSY: begin
                if (win_vld_s) begin
                    state_s = BUSY;
                    cnt_s   = {CW{1'b0}};
                end else if (done_cyc_s) begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = BUSY;
                    cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CW{1'b0}};
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Grant latching, memory strobe and held read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= {PW{1'b0}};
            rr_ptr_r    <= PTR_INIT;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            rdata_r     <= {DATA_W{1'b0}};
        end else begin
            mem_en_r <= win_vld_s;
            if (win_vld_s) begin
                owner_r     <= win_s;
                rr_ptr_r    <= win_s;
                mem_wr_r    <= wr[win_s];
                mem_addr_r  <= addr[win_s*ADDR_W +: ADDR_W];
                mem_wdata_r <= wdata[win_s*DATA_W +: DATA_W];
            end
            if (rd_done_s) begin
                rdata_r <= mem_rdata;
            end
        end
    end

    assign done      = done_cyc_s ? (ONE_HOT0 << owner_r) : {NUM_PORTS{1'b0}};
    assign stall     = req & ~done;
    assign rdata     = rd_done_s ? mem_rdata : rdata_r;
    assign mem_en    = mem_en_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench for mem_arbiter_n: three instances (fixed N=2, round-robin N=3, latency 1).
// Stimulus queues expected grants/completions; a negedge monitor pops and compares.
module tb_mem_arbiter_n;

    typedef struct { int inst; int port; logic [15:0] data; int cyc; } done_t;
    typedef struct { int inst; logic [15:0] addr; logic wr; logic [15:0] wdata; int cyc; } en_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   en_cyc_f = -100;
    int   en_cyc_r = -100;
    done_t dq[$];
    en_t   eq[$];

    // instance 0: fixed, N=2, latency 4
    logic [1:0]  req_f, wr_f, stall_f, done_f;
    logic [31:0] addr_f, wdata_f;
    logic [15:0] rdata_f, mem_addr_f, mem_wdata_f, mem_rdata_f;
    logic        mem_en_f, mem_wr_f;
    // instance 1: round-robin, N=3, latency 4
    logic [2:0]  req_r, wr_r, stall_r, done_r;
    logic [47:0] addr_r, wdata_r;
    logic [15:0] rdata_r, mem_addr_r, mem_wdata_r, mem_rdata_r;
    logic        mem_en_r, mem_wr_r;
    // instance 2: fixed, N=2, latency 1
    logic [1:0]  req_l, wr_l, stall_l, done_l;
    logic [31:0] addr_l, wdata_l;
    logic [15:0] rdata_l, mem_addr_l, mem_wdata_l, mem_rdata_l;
    logic        mem_en_l, mem_wr_l;

    function automatic logic [15:0] memf(input logic [15:0] a);
        memf = (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    // Backing memory: data valid only in the cycle MEM_LATENCY after the issuing edge
    assign mem_rdata_f = (cyc == en_cyc_f + 3) ? memf(mem_addr_f) : 16'hDEAD;
    assign mem_rdata_r = (cyc == en_cyc_r + 3) ? memf(mem_addr_r) : 16'hDEAD;
    assign mem_rdata_l = mem_en_l ? memf(mem_addr_l) : 16'hDEAD;

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(4), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .req(req_f), .wr(wr_f), .addr(addr_f), .wdata(wdata_f),
        .stall(stall_f), .done(done_f), .rdata(rdata_f), .mem_en(mem_en_f), .mem_wr(mem_wr_f),
        .mem_addr(mem_addr_f), .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f));

    mem_arbiter_n #(.NUM_PORTS(3), .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_r), .wr(wr_r), .addr(addr_r), .wdata(wdata_r),
        .stall(stall_r), .done(done_r), .rdata(rdata_r), .mem_en(mem_en_r), .mem_wr(mem_wr_r),
        .mem_addr(mem_addr_r), .mem_wdata(mem_wdata_r), .mem_rdata(mem_rdata_r));

    mem_arbiter_n #(.NUM_PORTS(2), .ADDR_W(16), .DATA_W(16), .MEM_LATENCY(1), .RR_MODE(0)) u_l1 (
        .clk(clk), .rst_n(rst_n), .req(req_l), .wr(wr_l), .addr(addr_l), .wdata(wdata_l),
        .stall(stall_l), .done(done_l), .rdata(rdata_l), .mem_en(mem_en_l), .mem_wr(mem_wr_l),
        .mem_addr(mem_addr_l), .mem_wdata(mem_wdata_l), .mem_rdata(mem_rdata_l));

    logic [2:0]  done_a [3];
    logic [15:0] rdata_a [3];
    logic        mem_en_a [3];
    logic        mem_wr_a [3];
    logic [15:0] mem_addr_a [3];
    logic [15:0] mem_wdata_a [3];
    assign done_a[0] = {1'b0, done_f};
    assign done_a[1] = done_r;
    assign done_a[2] = {1'b0, done_l};
    assign rdata_a[0] = rdata_f;
    assign rdata_a[1] = rdata_r;
    assign rdata_a[2] = rdata_l;
    assign mem_en_a[0] = mem_en_f;
    assign mem_en_a[1] = mem_en_r;
    assign mem_en_a[2] = mem_en_l;
    assign mem_wr_a[0] = mem_wr_f;
    assign mem_wr_a[1] = mem_wr_r;
    assign mem_wr_a[2] = mem_wr_l;
    assign mem_addr_a[0] = mem_addr_f;
    assign mem_addr_a[1] = mem_addr_r;
    assign mem_addr_a[2] = mem_addr_l;
    assign mem_wdata_a[0] = mem_wdata_f;
    assign mem_wdata_a[1] = mem_wdata_r;
    assign mem_wdata_a[2] = mem_wdata_l;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_en_f) en_cyc_f <= cyc;
        if (mem_en_r) en_cyc_r <= cyc;
    end

    // Monitor: pop expected grant/completion whenever an instance presents one
    always @(negedge clk) begin
        done_t d;
        en_t   e;
        for (int i = 0; i < 3; i++) begin
            if (done_a[i] != 3'b000) begin
                if (dq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: inst %0d got %0h expected none (cycle %0d)", i, done_a[i], cyc);
                end else begin
                    d = dq.pop_front();
                    chk("done_inst", i, d.inst);
                    chk("done_vec", {29'd0, done_a[i]}, 32'd1 << d.port);
                    chk("done_cyc", cyc, d.cyc);
                    chk("rdata", {16'd0, rdata_a[i]}, {16'd0, d.data});
                end
            end
            if (mem_en_a[i]) begin
                if (eq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_mem_en: inst %0d got 1 expected 0 (cycle %0d)", i, cyc);
                end else begin
                    e = eq.pop_front();
                    chk("en_inst", i, e.inst);
                    chk("en_cyc", cyc, e.cyc);
                    chk("mem_addr", {16'd0, mem_addr_a[i]}, {16'd0, e.addr});
                    chk("mem_wr", {31'd0, mem_wr_a[i]}, {31'd0, e.wr});
                    chk("mem_wdata", {16'd0, mem_wdata_a[i]}, {16'd0, e.wdata});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        req_f = 2'b00; wr_f = 2'b00; addr_f = 32'd0; wdata_f = 32'd0;
        req_r = 3'b000; wr_r = 3'b000; addr_r = 48'd0; wdata_r = 48'd0;
        req_l = 2'b00; wr_l = 2'b00; addr_l = 32'd0; wdata_l = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en_f}, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr_f}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr_f}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata_f}, 32'd0);
        chk("rst_done", {30'd0, done_f}, 32'd0);
        chk("rst_rdata", {16'd0, rdata_f}, 32'd0);
        chk("rst_done_rr", {29'd0, done_r}, 32'd0);
        chk("rst_mem_en_l1", {31'd0, mem_en_l}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single read port 0, addr 0x0010 -> 0xBEEF
        t = cyc;
        req_f[0] = 1'b1; addr_f[15:0] = 16'h0010;
        eq.push_back('{0, 16'h0010, 1'b0, 16'h0000, t + 1});
        dq.push_back('{0, 0, 16'hBEEF, t + 4});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t1_stall0", {31'd0, stall_f[0]}, {31'd0, (k < 4)});
            @(posedge clk); #1;
        end
        req_f[0] = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Write port 1 leaves rdata at 0xBEEF
        t = cyc;
        req_f[1] = 1'b1; wr_f[1] = 1'b1; addr_f[31:16] = 16'h0100; wdata_f[31:16] = 16'h1234;
        eq.push_back('{0, 16'h0100, 1'b1, 16'h1234, t + 1});
        dq.push_back('{0, 1, 16'hBEEF, t + 4});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_stall1", {31'd0, stall_f[1]}, {31'd0, (k < 4)});
            @(posedge clk); #1;
        end
        req_f[1] = 1'b0; wr_f[1] = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Fixed priority: both request, port 1 first, port 0 zero-bubble; addr1 change ignored
        t = cyc;
        req_f = 2'b11; addr_f = {16'h0031, 16'h0020}; wdata_f = {16'h0B0B, 16'h0A0A};
        eq.push_back('{0, 16'h0031, 1'b0, 16'h0B0B, t + 1});
        dq.push_back('{0, 1, memf(16'h0031), t + 4});
        eq.push_back('{0, 16'h0020, 1'b0, 16'h0A0A, t + 5});
        dq.push_back('{0, 0, memf(16'h0020), t + 8});
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk("t3_stall0", {31'd0, stall_f[0]}, {31'd0, (k < 8)});
            chk("t3_stall1", {31'd0, stall_f[1]}, {31'd0, (k < 4)});
            @(posedge clk); #1;
            if (k == 1) addr_f[31:16] = 16'hFFFF;
            if (k == 4) req_f[1] = 1'b0;
        end
        req_f[0] = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Reset at T+2 of an active read: no done, outputs cleared, regrant after release
        t = cyc;
        req_f[0] = 1'b1; addr_f[15:0] = 16'h0040; wdata_f[15:0] = 16'h7777;
        eq.push_back('{0, 16'h0040, 1'b0, 16'h7777, t + 1});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_mem_en", {31'd0, mem_en_f}, 32'd0);
        chk("ar_mem_addr", {16'd0, mem_addr_f}, 32'd0);
        chk("ar_mem_wdata", {16'd0, mem_wdata_f}, 32'd0);
        chk("ar_done", {30'd0, done_f}, 32'd0);
        chk("ar_rdata", {16'd0, rdata_f}, 32'd0);
        chk("ar_stall0", {31'd0, stall_f[0]}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        t = cyc;
        eq.push_back('{0, 16'h0040, 1'b0, 16'h7777, t + 1});
        dq.push_back('{0, 0, memf(16'h0040), t + 4});
        repeat (5) @(posedge clk); #1;
        req_f[0] = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Round-robin, 3 ports continuously requesting: 0,1,2,0,1
        t = cyc;
        req_r = 3'b111;
        addr_r = {16'h0202, 16'h0201, 16'h0200};
        wdata_r = {16'h3330, 16'h2220, 16'h1110};
        for (int g = 0; g < 5; g++) begin
            int p;
            p = g % 3;
            eq.push_back('{1, 16'h0200 + 16'(p), 1'b0, 16'h1110 * 16'(p + 1), t + 1 + 4 * g});
            dq.push_back('{1, p, memf(16'h0200 + 16'(p)), t + 4 + 4 * g});
        end
        repeat (11) @(posedge clk);
        @(negedge clk);
        chk("rr_stall2", {31'd0, stall_r[2]}, 32'd1);
        repeat (6) @(posedge clk); #1;
        req_r = 3'b000;
        repeat (6) @(posedge clk); #1;

        // Latency 1 back-to-back: port 1 then port 0, done coincident with mem_en
        t = cyc;
        req_l = 2'b11; addr_l = {16'h0301, 16'h0300};
        eq.push_back('{2, 16'h0301, 1'b0, 16'h0000, t + 1});
        dq.push_back('{2, 1, memf(16'h0301), t + 1});
        eq.push_back('{2, 16'h0300, 1'b0, 16'h0000, t + 2});
        dq.push_back('{2, 0, memf(16'h0300), t + 2});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("l1_stall0", {31'd0, stall_l[0]}, {31'd0, (k < 2)});
            chk("l1_stall1", {31'd0, stall_l[1]}, {31'd0, (k < 1)});
            @(posedge clk); #1;
            if (k == 1) req_l[1] = 1'b0;
            if (k == 2) req_l[0] = 1'b0;
        end

        for (int w = 0; w < 50 && (dq.size() != 0 || eq.size() != 0); w++) @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done_queue_drained", dq.size(), 32'd0);
        chk("en_queue_drained", eq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
